// File: rtl/ccta_result_acc.sv
// Frame accumulator for CCTA result samples: collects sum, max, min, sample count
// and ctrl-tag count over a frame of programmable length.
module ccta_result_acc #(
    parameter int DW = 5,
    parameter int LW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [LW-1:0]    frame_len,
    input  logic             in_valid,
    input  logic [DW-1:0]    q_in,
    input  logic             ctrl_in,
    output logic             in_ready,
    output logic [DW+LW-1:0] sum_out,
    output logic [DW-1:0]    max_out,
    output logic [DW-1:0]    min_out,
    output logic [LW:0]      count_out,
    output logic [LW:0]      tag_cnt,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    localparam logic [LW:0] FULL_FRAME = {1'b1, {LW{1'b0}}};

    stateT               r_state;
    logic [LW-1:0]       r_len;
    logic [DW+LW-1:0]    r_sum;
    logic [DW-1:0]       r_max;
    logic [DW-1:0]       r_min;
    logic [LW:0]         r_count;
    logic [LW:0]         r_tag;
    logic                r_busy;
    logic                r_done;

    logic [LW:0]         w_target;
    logic [LW:0]         w_countNext;
    logic [LW:0]         w_tagNext;
    logic [DW+LW-1:0]    w_sumNext;

    // A latched length of zero encodes the maximum frame of 2^LW samples.
    assign w_target    = (r_len == '0) ? FULL_FRAME : {1'b0, r_len};
    assign w_countNext = r_count + 1'b1;
    assign w_tagNext   = r_tag + {{LW{1'b0}}, ctrl_in};
    assign w_sumNext   = r_sum + {{LW{1'b0}}, q_in};

    assign in_ready  = (r_state == RUN);
    assign sum_out   = r_sum;
    assign max_out   = r_max;
    assign min_out   = r_min;
    assign count_out = r_count;
    assign tag_cnt   = r_tag;
    assign busy      = r_busy;
    assign done      = r_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_sum   <= '0;
            r_max   <= '0;
            r_min   <= '1;
            r_count <= '0;
            r_tag   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_len   <= frame_len;
                        r_sum   <= '0;
                        r_max   <= '0;
                        r_min   <= '1;
                        r_count <= '0;
                        r_tag   <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    // Abort wins over a sample presented on the same edge.
                    if (abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (in_valid) begin
                        r_sum   <= w_sumNext;
                        r_count <= w_countNext;
                        r_tag   <= w_tagNext;
                        if (q_in > r_max) r_max <= q_in;
                        if (q_in < r_min) r_min <= q_in;
                        if (w_countNext == w_target) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ccta_result_acc.md
CCTA_RESULT_ACC -- requirements
Module: ccta_result_acc

Interface
REQ-001 Parameter: DW, default 5, result sample width; matches the 5-bit CCTA q output.
REQ-002 Parameter: LW, default 4, frame-length field width; maximum frame is 2^LW samples.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 start  input  1  begins a frame when sampled high in IDLE or DONE.
REQ-007 abort  input  1  terminates a frame in progress.
REQ-008 frame_len  input  LW  samples per frame, latched at start; 0 means 2^LW.
REQ-009 in_valid  input  1  q_in/ctrl_in hold a valid sample.
REQ-010 q_in  input  DW  result sample from the CCTA stage.
REQ-011 ctrl_in  input  1  ctrl tag that produced the sample.
REQ-012 in_ready  output  1  block accepts a sample this cycle.
REQ-013 sum_out  output  DW+LW  sum of accepted samples.
REQ-014 max_out  output  DW  largest accepted sample.
REQ-015 min_out  output  DW  smallest accepted sample.
REQ-016 count_out  output  LW+1  number of accepted samples.
REQ-017 tag_cnt  output  LW+1  number of accepted samples with ctrl_in=1.
REQ-018 busy  output  1  high in RUN.
REQ-019 done  output  1  one-cycle frame-complete pulse.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-021 From IDLE with start=1, the FSM SHALL enter RUN at the next edge and take the following actions at that edge:
- latch frame_len;
- clear sum_out, count_out and tag_cnt;
- set max_out to 0 and min_out to all-ones.
REQ-022 in_ready SHALL equal 1 only in RUN, combinationally from state; a sample is accepted on an edge where in_valid=1 and in_ready=1.
REQ-023 On each accepted sample, the outputs SHALL update at that edge as follows:
- sum_out += q_in, zero-extended; no overflow is possible at the parameter widths;
- count_out += 1;
- tag_cnt += ctrl_in;
- max_out and min_out update with unsigned compare.
REQ-024 When the accepted sample makes count_out equal the latched length (0 treated as 2^LW), the FSM SHALL enter DONE at that same edge.
REQ-025 done SHALL be 1 for exactly the one cycle spent in DONE, i.e. one cycle after the last sample's accept edge.
REQ-026 From DONE, the FSM SHALL go to RUN if start=1, performing the REQ-021 initialisation; otherwise it SHALL go to IDLE.
REQ-027 Results SHALL hold unchanged in DONE and IDLE until the next frame starts.
REQ-028 start SHALL be ignored while in RUN.
REQ-029 abort=1 in RUN SHALL force IDLE at the next edge with no done pulse; partial results hold, and any sample presented on that edge is not accepted.
REQ-030 abort SHALL have priority over a sample arriving in the same cycle.
REQ-031 abort SHALL be ignored in IDLE and DONE.
REQ-032 in_valid=0 cycles in RUN SHALL stall without changing any state.
REQ-033 q_in and ctrl_in SHALL be ignored when the block is not accepting a sample.

Reset
REQ-034 When rst=0 at a clock edge, the block SHALL enter IDLE, overriding start and abort.
REQ-035 Reset values: sum_out=0, max_out=0, min_out=all-ones, count_out=0, tag_cnt=0, done=0, busy=0, in_ready=0, latched length=0.
REQ-036 Reset asserted mid-frame SHALL discard the frame with no done pulse.

Verification
REQ-037 The bench SHALL cover each of the following directed scenarios:
- Basic frame: start, frame_len=4, samples 0E/c0, 1A/c0, 08/c1, 1F/c1 back-to-back -> done one cycle after the 4th accept; sum_out=04F, max_out=1F, min_out=08, count_out=4, tag_cnt=2.
- Stalls: same frame with in_valid low 2 cycles between samples -> identical results; in_ready=1 throughout RUN.
- Full frame: frame_len=0 with 16 samples of 1F -> sum_out=1F0, count_out=16, done after the 16th sample only.
- Abort: abort asserted after 2 accepted samples -> IDLE, no done, count_out=2, in_ready=0; next start clears all results.
- Reset mid-frame: rst=0 during RUN -> all outputs at reset values next cycle, min_out=1F.
- Restart: start held high in DONE -> RUN next cycle, results cleared, done pulses exactly once per frame.
